// File: rtl/reg_access_ctrl_if.sv
// Command/response handshake and register-slave bus of reg_access_ctrl.
// The slave modport is the controller's view; master is the requester/slave-model view.
interface reg_access_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic                  cmd_verify;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_mismatch;

    logic [ADDR_WIDTH-1:0] reg_addr;
    logic                  reg_write_enable;
    logic                  reg_read_enable;
    logic [DATA_WIDTH-1:0] reg_write_data;
    logic [DATA_WIDTH-1:0] reg_read_data;

    logic                  busy;
    logic [15:0]           txn_count;

    modport slave (
        input  cmd_valid, cmd_write, cmd_verify, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_mismatch,
        input  rsp_ready,
        output reg_addr, reg_write_enable, reg_read_enable, reg_write_data,
        input  reg_read_data,
        output busy, txn_count
    );

    modport master (
        output cmd_valid, cmd_write, cmd_verify, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_mismatch,
        output rsp_ready,
        input  reg_addr, reg_write_enable, reg_read_enable, reg_write_data,
        output reg_read_data,
        input  busy, txn_count
    );
endinterface

// File: rtl/reg_access_ctrl.sv
// Register access controller: turns one command into a write and/or read strobe on a
// register slave, optionally verifying a write by reading it back, then holds a response.
module reg_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    reg_access_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic                  r_busy;
    logic                  r_verify;
    logic                  r_mismatch;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [15:0]           r_txn_count;
    logic                  w_accept;

    // Read-back compare; only a verified write can report a mismatch.
    function automatic logic verify_fail(
        input logic                  verify,
        input logic [DATA_WIDTH-1:0] rdata,
        input logic [DATA_WIDTH-1:0] wdata
    );
        return verify & (rdata != wdata);
    endfunction

    assign w_accept = bus.cmd_valid & r_cmd_ready;

    // Transaction FSM; strobes and handshake flags are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_verify    <= 1'b0;
            r_mismatch  <= 1'b0;
            r_addr      <= {ADDR_WIDTH{1'b0}};
            r_wdata     <= {DATA_WIDTH{1'b0}};
            r_rdata     <= {DATA_WIDTH{1'b0}};
            r_txn_count <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Verify only has meaning for writes, so it is dropped for reads here.
                        r_verify    <= bus.cmd_write & bus.cmd_verify;
                        r_addr      <= bus.cmd_addr;
                        r_wdata     <= bus.cmd_wdata;
                        r_rdata     <= {DATA_WIDTH{1'b0}};
                        r_mismatch  <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.cmd_write) begin
                            r_state <= S_WRITE;
                            r_wr_en <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            r_rd_en <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    r_wr_en <= 1'b0;
                    if (r_verify) begin
                        r_state <= S_READ;
                        r_rd_en <= 1'b1;
                    end else begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_READ: begin
                    r_rd_en     <= 1'b0;
                    r_rdata     <= bus.reg_read_data;
                    r_mismatch  <= verify_fail(r_verify, bus.reg_read_data, r_wdata);
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_txn_count <= r_txn_count + 16'd1;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_wr_en     <= 1'b0;
                    r_rd_en     <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready        = r_cmd_ready;
    assign bus.rsp_valid        = r_rsp_valid;
    assign bus.rsp_rdata        = r_rdata;
    assign bus.rsp_mismatch     = r_mismatch;
    assign bus.reg_addr         = r_addr;
    assign bus.reg_write_enable = r_wr_en;
    assign bus.reg_read_enable  = r_rd_en;
    assign bus.reg_write_data   = r_wdata;
    assign bus.busy             = r_busy;
    assign bus.txn_count        = r_txn_count;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed, table-driven bench for reg_access_ctrl with a small 4-entry register slave
// model (optionally forcing stored bit 0 low) and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_reg_access_ctrl;
    localparam int DW = 8;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register slave model
    logic [DW-1:0] mem [4];
    logic          fault;
    assign bus.reg_read_data = bus.reg_read_enable ? mem[bus.reg_addr] : 8'h00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
        end else if (bus.reg_write_enable) begin
            mem[bus.reg_addr] <= fault ? (bus.reg_write_data & 8'hFE) : bus.reg_write_data;
        end
    end

    // Strobe monitor
    int            cyc = 0;
    int            wr_pulses = 0;
    int            rd_pulses = 0;
    int            overlap = 0;
    int            last_wr_cyc = 0;
    int            last_rd_cyc = 0;
    logic [AW-1:0] last_wr_addr = 2'd0;
    logic [DW-1:0] last_wr_data = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.reg_write_enable) begin
            wr_pulses    <= wr_pulses + 1;
            last_wr_cyc  <= cyc;
            last_wr_addr <= bus.reg_addr;
            last_wr_data <= bus.reg_write_data;
        end
        if (bus.reg_read_enable) begin
            rd_pulses   <= rd_pulses + 1;
            last_rd_cyc <= cyc;
        end
        if (bus.reg_write_enable && bus.reg_read_enable) overlap <= overlap + 1;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_txn  = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          wr;
        logic          vf;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          flt;
        logic [DW-1:0] e_rdata;
        logic          e_mm;
        int            e_lat;
        int            e_wr;
        int            e_rd;
    } vec_t;

    vec_t vecs [11];

    task automatic run_txn(input vec_t v);
        int n;
        int w0;
        int r0;
        fault = v.flt;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_write  = v.wr;
        bus.cmd_verify = v.vf;
        bus.cmd_addr   = v.addr;
        bus.cmd_wdata  = v.wdata;
        w0 = wr_pulses;
        r0 = rd_pulses;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        n = 1;
        while (1) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1 || n >= 10) break;
            @(posedge clk);
            n++;
        end
        check("latency", n, v.e_lat);
        check("rsp_rdata", bus.rsp_rdata, v.e_rdata);
        check("rsp_mismatch", bus.rsp_mismatch, v.e_mm);
        check("cmd_ready_in_resp", bus.cmd_ready, 0);
        check("busy_in_resp", bus.busy, 1);
        @(posedge clk);
        #1;
        exp_txn = exp_txn + 16'd1;
        check("txn_count", bus.txn_count, exp_txn);
        check("rsp_valid_after_done", bus.rsp_valid, 0);
        check("busy_after_done", bus.busy, 0);
        check("wr_pulses", wr_pulses - w0, v.e_wr);
        check("rd_pulses", rd_pulses - r0, v.e_rd);
        if (v.e_wr > 0) begin
            check("wr_addr", last_wr_addr, v.addr);
            check("wr_data", last_wr_data, v.wdata);
        end
        if (v.wr && v.vf) check("verify_read_next_cycle", last_rd_cyc - last_wr_cyc, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        vec_t rd0;
        //            wr    vf    addr  wdata  flt   e_rdata e_mm lat wr rd
        vecs[0]  = '{1'b1, 1'b0, 2'd2, 8'hA5, 1'b0, 8'h00, 1'b0, 2, 1, 0};
        vecs[1]  = '{1'b1, 1'b0, 2'd1, 8'h3C, 1'b0, 8'h00, 1'b0, 2, 1, 0};
        vecs[2]  = '{1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 8'h3C, 1'b0, 2, 0, 1};
        vecs[3]  = '{1'b1, 1'b1, 2'd0, 8'h5A, 1'b0, 8'h5A, 1'b0, 3, 1, 1};
        vecs[4]  = '{1'b1, 1'b1, 2'd3, 8'hFF, 1'b1, 8'hFE, 1'b1, 3, 1, 1};
        vecs[5]  = '{1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'hFE, 1'b0, 2, 0, 1};
        vecs[6]  = '{1'b0, 1'b1, 2'd1, 8'h3C, 1'b0, 8'h3C, 1'b0, 2, 0, 1};
        vecs[7]  = '{1'b1, 1'b1, 2'd0, 8'h01, 1'b1, 8'h00, 1'b1, 3, 1, 1};
        vecs[8]  = '{1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0, 3, 1, 1};
        vecs[9]  = '{1'b0, 1'b0, 2'd2, 8'h00, 1'b0, 8'hA5, 1'b0, 2, 0, 1};
        vecs[10] = '{1'b1, 1'b0, 2'd3, 8'h66, 1'b1, 8'h00, 1'b0, 2, 1, 0};
        rd0      = '{1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0, 2, 0, 1};

        reset          = 1'b1;
        fault          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.cmd_verify = 1'b0;
        bus.cmd_addr   = 2'd0;
        bus.cmd_wdata  = 8'h00;
        bus.rsp_ready  = 1'b1;

        // Outputs while reset is held
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_mismatch", bus.rsp_mismatch, 0);
        check("rst_we", bus.reg_write_enable, 0);
        check("rst_re", bus.reg_read_enable, 0);
        check("rst_reg_addr", bus.reg_addr, 0);
        check("rst_reg_wdata", bus.reg_write_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_txn_count", bus.txn_count, 0);
        reset = 1'b0;

        // Table vectors; the first is accepted on the first edge after reset release
        for (int i = 0; i < 11; i++) run_txn(vecs[i]);
        check("no_strobe_overlap", overlap, 0);
        check("idle_holds_addr", bus.reg_addr, 2'd3);
        check("idle_holds_wdata", bus.reg_write_data, 8'h66);
        fault = 1'b0;

        // Response back-pressure with a command waiting
        @(negedge clk);
        bus.rsp_ready  = 1'b0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_write  = 1'b0;
        bus.cmd_verify = 1'b0;
        bus.cmd_addr   = 2'd2;
        @(posedge clk);
        #1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 2'd0;
        bus.cmd_wdata = 8'h11;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid_seen", bus.rsp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid_held", bus.rsp_valid, 1);
            check("bp_rdata_held", bus.rsp_rdata, 8'hA5);
            check("bp_cmd_ready_low", bus.cmd_ready, 0);
            check("bp_no_strobes", {bus.reg_write_enable, bus.reg_read_enable}, 2'b00);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_txn = exp_txn + 16'd1;
        check("bp_txn_count", bus.txn_count, exp_txn);
        check("bp_idle_cmd_ready", bus.cmd_ready, 1);
        check("bp_idle_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("bp_next_accepted_we", bus.reg_write_enable, 1);
        check("bp_next_addr", bus.reg_addr, 2'd0);
        check("bp_next_wdata", bus.reg_write_data, 8'h11);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_next_rsp_valid", bus.rsp_valid, 1);
        check("bp_next_rdata", bus.rsp_rdata, 8'h00);
        @(posedge clk);
        #1;
        exp_txn = exp_txn + 16'd1;
        check("bp_next_txn_count", bus.txn_count, exp_txn);

        // Reset in the middle of a verified write
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_write  = 1'b1;
        bus.cmd_verify = 1'b1;
        bus.cmd_addr   = 2'd1;
        bus.cmd_wdata  = 8'h77;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("abort_we_before", bus.reg_write_enable, 1);
        r0 = rd_pulses;
        #2;
        reset = 1'b1;
        #1;
        check("abort_we_drop", bus.reg_write_enable, 0);
        check("abort_re_low", bus.reg_read_enable, 0);
        check("abort_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        check("abort_no_rsp", bus.rsp_valid, 0);
        check("abort_no_read", rd_pulses - r0, 0);
        check("abort_txn_count", bus.txn_count, 0);
        reset = 1'b0;
        exp_txn = 16'd0;

        // Counter wrap from a preloaded value
        @(negedge clk);
        force dut.r_txn_count = 16'hFFFE;
        #1;
        release dut.r_txn_count;
        exp_txn = 16'hFFFE;
        check("wrap_preload", bus.txn_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) run_txn(rd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of the data path to and from the register slave.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 2, meaning the width of the slave register address.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port cmd_valid  input  1  command present.
REQ-006 The block SHALL have port cmd_ready  output  1  command accepted this cycle when high together with cmd_valid.
REQ-007 The block SHALL have ports cmd_write (input, 1, 1 = write / 0 = read), cmd_verify (input, 1, read back after write), cmd_addr (input, ADDR_WIDTH) and cmd_wdata (input, DATA_WIDTH).
REQ-008 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_rdata (output, DATA_WIDTH) and rsp_mismatch (output, 1, verify failed).
REQ-009 The block SHALL have slave-side ports reg_addr (output, ADDR_WIDTH), reg_write_enable (output, 1), reg_read_enable (output, 1), reg_write_data (output, DATA_WIDTH) and reg_read_data (input, DATA_WIDTH; combinational from slave, zero when read disabled).
REQ-010 The block SHALL have ports busy (output, 1, state not IDLE) and txn_count (output, 16, completed transactions).

Function
REQ-011 The FSM SHALL have the states IDLE, WRITE, READ and RESP, encoded in registers; all slave-side strobes SHALL be decoded from the state register only.
REQ-012 In IDLE, cmd_ready SHALL be 1; in all other states it SHALL be 0.
REQ-013 On cmd_valid && cmd_ready, the block SHALL latch write, verify, addr and wdata, clear captured rdata and mismatch, and go to WRITE if cmd_write = 1, otherwise to READ.
REQ-014 In WRITE, the block SHALL assert reg_write_enable = 1 for exactly one cycle, with reg_addr and reg_write_data driving the latched values.
REQ-015 From WRITE, the next state SHALL be READ if verify = 1, otherwise RESP.
REQ-016 In READ, the block SHALL assert reg_read_enable = 1 for exactly one cycle and capture reg_read_data into rsp_rdata on the closing clock edge; the next state SHALL be RESP.
REQ-017 cmd_verify SHALL be ignored when cmd_write = 0.
REQ-018 On a verify transaction, rsp_mismatch SHALL be 1 when captured rdata != latched wdata; in all other cases it SHALL be 0.
REQ-019 For a write transaction without verify, rsp_rdata SHALL be 0.
REQ-020 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_mismatch SHALL be held stable until rsp_ready = 1; on that edge the block SHALL return to IDLE.
REQ-021 The handshake rules SHALL be: rsp_valid is never withdrawn before rsp_ready; rsp_valid and cmd_ready are never high in the same cycle; a command cannot be accepted in the cycle its response completes.
REQ-022 The latencies from the accept edge to the first rsp_valid cycle SHALL be: read 2 cycles, plain write 2 cycles, verified write 3 cycles.
REQ-023 reg_write_enable and reg_read_enable SHALL never be high in the same cycle; outside WRITE and READ, both SHALL be 0.
REQ-024 txn_count SHALL increment by 1 on each rsp_valid && rsp_ready, wrapping from 16'hFFFF to 0.
REQ-025 busy SHALL be 1 in all states except IDLE.
REQ-026 When idle, reg_addr and reg_write_data SHALL hold the last latched values.
REQ-027 cmd_valid held high while the block is not in IDLE SHALL be ignored and SHALL be accepted on the first IDLE cycle.

Reset
REQ-028 On assertion of reset, the block SHALL immediately enter IDLE, regardless of clk.
REQ-029 During reset, the outputs SHALL be cmd_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_mismatch = 0, reg_write_enable = 0, reg_read_enable = 0, reg_addr = 0, reg_write_data = 0, busy = 0 and txn_count = 0.
REQ-030 A reset asserted in WRITE, READ or RESP SHALL abort the transaction with no response issued and no strobe extended past reset assertion.
REQ-031 The first command SHALL be acceptable on the first rising clk edge after reset deasserts.

Verification
REQ-032 Write addr 2, data 8'hA5, no verify, rsp_ready = 1 -> exactly one reg_write_enable pulse with reg_addr = 2 and reg_write_data = 8'hA5; rsp_valid 2 cycles after the accept edge with rsp_rdata = 0 and rsp_mismatch = 0; txn_count = 1.
REQ-033 Slave at addr 1 holds 8'h3C; read addr 1 -> exactly one reg_read_enable pulse; rsp_rdata = 8'h3C; rsp_valid 2 cycles after the accept edge.
REQ-034 Verified write of 8'h5A to a slave that stores it correctly -> write pulse, then read pulse on the next cycle, then rsp_mismatch = 0 and rsp_rdata = 8'h5A. Repeat with the slave forcing stored bit 0 to 0 on 8'hFF -> rsp_mismatch = 1 and rsp_rdata = 8'hFE.
REQ-035 Hold rsp_ready = 0 for 5 cycles in RESP with cmd_valid = 1 -> rsp_valid and rsp_rdata stable, cmd_ready = 0, no strobes; after rsp_ready = 1, the next command is accepted on the following cycle.
REQ-036 Assert reset mid-cycle during WRITE of a verified command -> reg_write_enable drops immediately, no read pulse, no rsp_valid, txn_count = 0.
REQ-037 Preload txn_count to 16'hFFFE via 2 transactions in a forced-initial test, or run 65537 reads -> txn_count wraps to 0 and then 1.
